// File: rtl/csa_pipe_accumulator.sv
// Pipelined M-operand carry-save adder with valid/ready flow control and an
// optional packet accumulation mode that folds beat sums into a wide accumulator.
module csa_pipe_accumulator #(
    parameter int M     = 6,
    parameter int N     = 4,
    parameter int ACC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M*N-1:0]     in_ops,
    input  logic               in_mode,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_ovf
);
    localparam int SW = N + $clog2(M);
    localparam int NS = M - 2;

    // Full-adder row: returns {carry << 1, sum}; the dropped carry MSB is
    // harmless because the exact beat sum always fits in SW bits.
    function automatic logic [2*SW-1:0] csa3(input logic [SW-1:0] a,
                                             input logic [SW-1:0] b,
                                             input logic [SW-1:0] c);
        logic [SW-1:0] carry;
        carry = ((a & b) | (a & c) | (b & c)) << 1;
        return {carry, a ^ b ^ c};
    endfunction

    logic             stall_s;
    logic             accept_s;
    logic [SW-1:0]    beat_sum_s;
    logic [ACC_W-1:0] beat_ext_s;
    logic [ACC_W-1:0] acc_sum_s;
    logic             acc_carry_s;
    logic [ACC_W-1:0] acc_new_s;
    logic             ovf_new_s;
    logic [ACC_W-1:0] acc_r;
    logic             ovf_acc_r;
    logic             acc_open_r;

    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s && rst_n;
    assign accept_s = in_valid && in_ready;

    for (genvar i = 0; i < NS; i++) begin : g_stg
        logic [SW-1:0] a_s, b_s, c_s;
        logic          in_v_s, in_m_s, in_l_s;
        logic          v_r, mode_r, last_r;
        logic [SW-1:0] st_r, ct_r;

        if (i == 0) begin : g_src
            assign a_s    = SW'(in_ops[0 +: N]);
            assign b_s    = SW'(in_ops[N +: N]);
            assign c_s    = SW'(in_ops[2*N +: N]);
            assign in_v_s = accept_s;
            assign in_m_s = in_mode;
            assign in_l_s = in_last;
        end else begin : g_src
            assign a_s    = g_stg[i-1].st_r;
            assign b_s    = g_stg[i-1].ct_r;
            assign c_s    = SW'(g_stg[i-1].g_pend.pend_r[N-1:0]);
            assign in_v_s = g_stg[i-1].v_r;
            assign in_m_s = g_stg[i-1].mode_r;
            assign in_l_s = g_stg[i-1].last_r;
        end

        // CSA level i: reduce three terms and advance the sideband bits
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r <= 1'b0;
            end else if (!stall_s) begin
                v_r              <= in_v_s;
                mode_r           <= in_m_s;
                last_r           <= in_l_s;
                {ct_r, st_r}     <= csa3(a_s, b_s, c_s);
            end
        end

        // Operands not yet consumed travel alongside, shrinking by one per level
        if (i < NS - 1) begin : g_pend
            logic [(M-3-i)*N-1:0] pend_s;
            logic [(M-3-i)*N-1:0] pend_r;

            if (i == 0) begin : g_in
                assign pend_s = in_ops[M*N-1:3*N];
            end else begin : g_in
                assign pend_s = g_stg[i-1].g_pend.pend_r[(M-2-i)*N-1:N];
            end

            // Pending operand register for this level
            always_ff @(posedge clk) begin
                if (!stall_s) begin
                    pend_r <= pend_s;
                end
            end
        end
    end

    // Final CPA and accumulator update candidates
    always_comb begin
        beat_sum_s                 = g_stg[NS-1].st_r + g_stg[NS-1].ct_r;
        beat_ext_s                 = ACC_W'(beat_sum_s);
        {acc_carry_s, acc_sum_s}   = {1'b0, acc_r} + {1'b0, beat_ext_s};
        if (acc_open_r) begin
            acc_new_s = acc_sum_s;
            ovf_new_s = ovf_acc_r | acc_carry_s;
        end else begin
            acc_new_s = beat_ext_s;
            ovf_new_s = 1'b0;
        end
    end

    // Output stage: emit per-beat sums directly, fold mode-1 beats into the packet
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sum    <= {ACC_W{1'b0}};
            out_ovf    <= 1'b0;
            acc_r      <= {ACC_W{1'b0}};
            ovf_acc_r  <= 1'b0;
            acc_open_r <= 1'b0;
        end else if (!stall_s) begin
            out_valid <= 1'b0;
            if (g_stg[NS-1].v_r) begin
                if (!g_stg[NS-1].mode_r) begin
                    out_sum   <= beat_ext_s;
                    out_ovf   <= 1'b0;
                    out_valid <= 1'b1;
                end else begin
                    acc_r      <= acc_new_s;
                    ovf_acc_r  <= ovf_new_s;
                    acc_open_r <= !g_stg[NS-1].last_r;
                    if (g_stg[NS-1].last_r) begin
                        out_sum   <= acc_new_s;
                        out_ovf   <= ovf_new_s;
                        out_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/csa_pipe_accumulator.md
# csa_pipe_accumulator

Pipelined, parametrised M-operand carry-save adder with valid/ready flow control and an optional packet accumulation mode. Each accepted beat carries M unsigned N-bit operands. The beat passes through a registered chain of M-2 carry-save levels and a final carry-propagate adder. The block then either emits the per-beat sum or folds it into a wide accumulator that is emitted on the packet's last beat. It sits between operand producers (multiplier partial-product generators, dot-product lanes) and downstream consumers that can stall.

## Interface
- M, default 6: operands per beat; legal range 3..16.
- N, default 4: operand width in bits; ≥1.
- ACC_W, default 16: accumulator and out_sum width; must be ≥ SW, where SW = N + $clog2(M).
- clk  in  1  rising-edge clock; the block has one clock.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready at a rising edge.
- in_ops  in  M*N  operand k occupies in_ops[k*N +: N]; unsigned.
- in_mode  in  1  0 = per-beat sum; 1 = accumulate.
- in_last  in  1  closes the accumulation packet; ignored when in_mode=0.
- out_valid  out  1  result held until out_ready.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_sum  out  ACC_W  result, zero-extended.
- out_ovf  out  1  accumulation overflowed ACC_W; always 0 for mode-0 results.

## Operation
- Stage structure:
  - CSA level 0 reduces operands 0,1,2.
  - Level i (1..M-3) reduces the previous St/Ct with operand 2+i.
  - Each level's St, Ct and pending operands are registered, giving M-2 register stages.
  - The final stage performs the CPA of St/Ct and registers the result.
  - Each stage carries sideband registers: valid, mode, last.
- Beat sum is exact: SW bits suffice for M*(2^N-1).
- Global stall: stall = out_valid && !out_ready.
  - While stalled, every pipeline register, the accumulator and the output registers hold.
  - in_ready = !stall && rst_n. Bubbles are not compressed during a stall.
- Final stage, mode 0 beat: out_sum <= zero-extended beat sum; out_ovf <= 0; out_valid <= 1. The accumulator is untouched.
- Final stage, mode 1 beat:
  - If it is the first beat of a packet (acc_open=0): acc <= sum and ovf_acc <= 0.
  - Otherwise: acc <= acc + sum mod 2^ACC_W, and ovf_acc <= ovf_acc | carry-out.
  - acc_open <= !last.
  - If last: out_sum <= the new acc value, out_ovf <= the new ovf_acc, out_valid <= 1, and acc_open <= 0.
  - Non-last mode-1 beats produce no output.
- Mode-0 beats may arrive while a packet is open. They are emitted independently and the open packet continues.
- out_valid clears on handshake unless a new result lands on the same edge. A new result lands only when not stalled, so no result is ever overwritten.
- Reset (rst_n=0 at an edge), including mid-packet:
  - All stage valid bits, out_valid, out_sum, out_ovf, acc, ovf_acc and acc_open are cleared to 0.
  - Any in-flight beats and any open packet are discarded.
  - in_ready is 0 while rst_n=0.

## Timing
- Latency L = M-1 edges: a beat accepted at edge E produces its result with out_valid=1 after edge E+L-1, when nothing stalls. For M=6, out_valid rises in the 5th cycle after acceptance. For M=3, L=2.
- Throughput: one beat per cycle while out_ready=1.
- in_ready drops combinationally in the same cycle that out_valid=1 and out_ready=0.
- Outputs are registered. out_sum and out_ovf are stable while out_valid=1 && out_ready=0.
- After reset release, in_ready=1 in the first cycle with rst_n=1.

## Test plan
All scenarios use M=6, N=4, ACC_W=16 unless stated.
- Single beat: all operands 15, mode 0, out_ready=1 → out_sum=90, out_ovf=0, out_valid after exactly 5 edges, high for 1 cycle.
- Streaming: 20 back-to-back random mode-0 beats → 20 results in order, one per cycle, each equal to the reference sum. in_ready stays 1 throughout.
- Backpressure: stream while out_ready is toggled pseudo-randomly → no loss or duplication. Outputs stay stable while stalled, and in_ready=0 exactly when out_valid && !out_ready.
- Accumulate: 3 mode-1 beats of all-15 operands, last on the 3rd → one output of 270 with out_ovf=0. A mode-0 beat with operands 1 inserted after beat 1 → an extra output of 6 between them, and the packet still totals 270.
- Overflow, ACC_W=8: 3 mode-1 beats of all-15, last on the 3rd → out_sum=14, out_ovf=1. The next packet, a single last beat of zeros → out_sum=0, out_ovf=0.
- Reset mid-operation: assert rst_n=0 for 1 cycle with 4 beats in flight and a packet open → out_valid=0 after the edge and no stale output appears. A new packet of one last beat of all-1 operands → out_sum=6.
